// File: rtl/uart_cmd_pkg.sv
// Shared opcodes and sequencer state encoding for the UART command path.
package uart_cmd_pkg;

  localparam logic [7:0] WR_CMD = 8'hAA;
  localparam logic [7:0] RD_CMD = 8'hBB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_EXEC,
    ST_RD_ADDR,
    ST_RD_EXEC,
    ST_RD_WAIT,
    ST_TX_SEND
  } state_t;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte watchdog counter: clears on clr, counts while run, flags the
// last allowed cycle. Built only when UART_CMD_TIMEOUT_EN is defined.
`ifdef UART_CMD_TIMEOUT_EN
module uart_cmd_timer #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt;

  assign expired_c = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Count idle cycles within a frame; saturate at the expiry value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (run && !expired_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: decodes write/read frames into register-file
// strobes and returns read data to the transmitter.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  input  logic [DATA_W-1:0] rf_rd_data,
  input  logic              rf_rd_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic              busy,
  output logic              frame_err
);

  state_t state;
  logic   addr_ok_c;
  logic   timeout_c;

  assign addr_ok_c = (rx_data[DATA_W-1:ADDR_W] == '0);

`ifdef UART_CMD_TIMEOUT_EN
  logic timer_run_c;
  logic timer_clr_c;

  assign timer_run_c = (state == ST_WR_ADDR) || (state == ST_WR_DATA) ||
                       (state == ST_RD_ADDR);
  assign timer_clr_c = rx_valid || !timer_run_c;

  uart_cmd_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (timer_run_c),
    .clr       (timer_clr_c),
    .expired_c (timeout_c)
  );
`else
  // Without the watchdog a partial frame waits forever.
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_c = 1'b0;
`endif

  // Frame sequencer with registered strobes, busy and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rf_addr    <= '0;
      rf_wr_data <= '0;
      tx_data    <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rf_wr_en  <= 1'b0;
      rf_rd_en  <= 1'b0;
      tx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            if (rx_data == DATA_W'(WR_CMD)) begin
              state <= ST_WR_ADDR;
              busy  <= 1'b1;
            end else if (rx_data == DATA_W'(RD_CMD)) begin
              state <= ST_RD_ADDR;
              busy  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        ST_WR_ADDR, ST_RD_ADDR: begin
          if (rx_valid) begin
            if (!addr_ok_c) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              frame_err <= 1'b1;
            end else begin
              rf_addr <= rx_data[ADDR_W-1:0];
              if (state == ST_WR_ADDR) begin
                state <= ST_WR_DATA;
              end else begin
                state    <= ST_RD_EXEC;
                rf_rd_en <= 1'b1;
              end
            end
          end else if (timeout_c) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end
        end
        ST_WR_DATA: begin
          if (rx_valid) begin
            rf_wr_data <= rx_data;
            rf_wr_en   <= 1'b1;
            state      <= ST_WR_EXEC;
          end else if (timeout_c) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end
        end
        ST_WR_EXEC: begin
          frame_err <= rx_valid;
          state     <= ST_IDLE;
          busy      <= 1'b0;
        end
        ST_RD_EXEC: begin
          frame_err <= rx_valid;
          state     <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          frame_err <= rx_valid;
          if (rf_rd_valid) begin
            tx_data <= rf_rd_data;
            state   <= ST_TX_SEND;
          end
        end
        ST_TX_SEND: begin
          frame_err <= rx_valid;
          if (!tx_busy) begin
            tx_valid <= 1'b1;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed protocol steps followed by
// random frames scored against a frame-level expectation model.
module tb_uart_cmd_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [7:0] rf_rd_data;
  logic       rf_rd_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy;
  logic       busy;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  int wr_q[$];
  int rd_q[$];
  int tx_q[$];
  int ferr_seen = 0;
  int exp_wr[$];
  int exp_rd[$];
  int exp_tx[$];

  uart_cmd_ctrl #(
    .DATA_W      (8),
    .ADDR_W      (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rf_addr     (rf_addr),
    .rf_wr_data  (rf_wr_data),
    .rf_wr_en    (rf_wr_en),
    .rf_rd_en    (rf_rd_en),
    .rf_rd_data  (rf_rd_data),
    .rf_rd_valid (rf_rd_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every observable event at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_wr_en)  wr_q.push_back(int'({rf_addr, rf_wr_data}));
      if (rf_rd_en)  rd_q.push_back(int'(rf_addr));
      if (tx_valid)  tx_q.push_back(int'(tx_data));
      if (frame_err) ferr_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Wait up to n cycles for a tx_valid pulse; reports whether it appeared.
  task automatic wait_tx(input int n, output bit seen, output logic [7:0] data);
    seen = 1'b0;
    data = '0;
    for (int i = 0; i < n && !seen; i++) begin
      tick();
      if (tx_valid) begin
        seen = 1'b1;
        data = tx_data;
      end
    end
  endtask

  initial begin
    bit         seen;
    logic [7:0] got;
    int         nwr;
    int         fbase;

    rst         = 1'b1;
    rx_data     = '0;
    rx_valid    = 1'b0;
    rf_rd_data  = '0;
    rf_rd_valid = 1'b0;
    tx_busy     = 1'b0;
    idle(3);

    // Reset values
    check("rst_outputs", {rf_wr_en, rf_rd_en, tx_valid, busy, frame_err}, 5'b0);
    check("rst_addr", rf_addr, 4'h0);
    check("rst_wr_data", rf_wr_data, 8'h00);
    check("rst_tx_data", tx_data, 8'h00);
    rst = 1'b0;
    idle(2);

    // Write AA 05 3C: strobe in the cycle after the data byte
    send_byte(8'hAA);
    check("wr_busy", busy, 1'b1);
    send_byte(8'h05);
    send_byte(8'h3C);
    check("wr_en", rf_wr_en, 1'b1);
    check("wr_addr", rf_addr, 4'h5);
    check("wr_data", rf_wr_data, 8'h3C);
    tick();
    check("wr_en_single", rf_wr_en, 1'b0);
    check("wr_busy_after", busy, 1'b0);

    // Read BB 0A, data returned three cycles after the read strobe
    send_byte(8'hBB);
    send_byte(8'h0A);
    check("rd_en", rf_rd_en, 1'b1);
    check("rd_addr", rf_addr, 4'hA);
    tick();
    check("rd_en_single", rf_rd_en, 1'b0);
    tick();
    rf_rd_data  = 8'h77;
    rf_rd_valid = 1'b1;
    tick();
    rf_rd_valid = 1'b0;
    wait_tx(5, seen, got);
    check("rd_tx_seen", seen, 1'b1);
    check("rd_tx_data", got, 8'h77);
    tick();
    check("rd_busy_after", busy, 1'b0);

    // Backpressure: tx held off for 20 busy cycles
    tx_busy = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h02);
    tick();
    rf_rd_data  = 8'hC5;
    rf_rd_valid = 1'b1;
    tick();
    rf_rd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_valid) seen = 1'b1;
    end
    check("bp_held", seen, 1'b0);
    check("bp_busy", busy, 1'b1);
    tx_busy = 1'b0;
    tick();
    check("bp_tx_valid", tx_valid, 1'b1);
    check("bp_tx_data", tx_data, 8'hC5);
    tick();

    // Bad opcode
    nwr = wr_q.size();
    send_byte(8'h12);
    check("badop_ferr", frame_err, 1'b1);
    check("badop_busy", busy, 1'b0);
    tick();
    check("badop_ferr_single", frame_err, 1'b0);
    check("badop_no_strobe", {rf_wr_en, rf_rd_en}, 2'b00);

    // Bad address byte
    send_byte(8'hAA);
    send_byte(8'h15);
    check("badaddr_ferr", frame_err, 1'b1);
    check("badaddr_idle", busy, 1'b0);
    tick();
    check("badaddr_no_write", wr_q.size(), nwr);

    // Overrun during RD_WAIT; read still completes
    send_byte(8'hBB);
    send_byte(8'h03);
    tick();
    send_byte(8'h55);
    check("ovr_ferr", frame_err, 1'b1);
    check("ovr_busy", busy, 1'b1);
    rf_rd_data  = 8'h99;
    rf_rd_valid = 1'b1;
    tick();
    rf_rd_valid = 1'b0;
    wait_tx(5, seen, got);
    check("ovr_tx_seen", seen, 1'b1);
    check("ovr_tx_data", got, 8'h99);
    tick();

    // Stray read-valid while idle is ignored
    rf_rd_data  = 8'h44;
    rf_rd_valid = 1'b1;
    tick();
    rf_rd_valid = 1'b0;
    wait_tx(4, seen, got);
    check("stray_rdv_no_tx", seen, 1'b0);
    check("stray_rdv_idle", busy, 1'b0);

    // Reset mid-frame aborts, next frame completes
    nwr = wr_q.size();
    send_byte(8'hAA);
    send_byte(8'h03);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_idle", busy, 1'b0);
    idle(3);
    check("midrst_no_write", wr_q.size(), nwr);
    send_byte(8'hAA);
    send_byte(8'h03);
    send_byte(8'h01);
    check("midrst_wr_en", rf_wr_en, 1'b1);
    check("midrst_wr", {rf_addr, rf_wr_data}, 12'h301);
    tick();

`ifdef UART_CMD_TIMEOUT_EN
    // Timeout: 16 silent cycles after an opcode abort the frame
    send_byte(8'hBB);
    idle(15);
    check("tmo_not_yet", {busy, frame_err}, 2'b10);
    tick();
    check("tmo_ferr", frame_err, 1'b1);
    check("tmo_idle", busy, 1'b0);
    send_byte(8'h0A);
    check("tmo_late_ferr", frame_err, 1'b1);
    tick();
`endif

    // Random frames scored against frame-level expectations
    idle(2);
    wr_q.delete();
    rd_q.delete();
    tx_q.delete();
    for (int f = 0; f < 40; f++) begin
      int         kind;
      int         exp_ferr;
      logic [7:0] a;
      logic [7:0] d;
      int         bcyc;
      kind     = int'($urandom_range(0, 3));
      exp_ferr = 0;
      fbase    = ferr_seen;
      case (kind)
        0: begin
          a = 8'($urandom_range(0, 15));
          d = 8'($urandom_range(0, 255));
          send_byte(8'hAA); idle(int'($urandom_range(0, 3)));
          send_byte(a);     idle(int'($urandom_range(0, 3)));
          send_byte(d);
          exp_wr.push_back(int'(a) * 256 + int'(d));
        end
        1: begin
          a = 8'($urandom_range(0, 15));
          d = 8'($urandom_range(0, 255));
          send_byte(8'hBB); idle(int'($urandom_range(0, 3)));
          send_byte(a);
          idle(int'($urandom_range(1, 4)));
          bcyc        = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0;
          tx_busy     = (bcyc != 0);
          rf_rd_data  = d;
          rf_rd_valid = 1'b1;
          tick();
          rf_rd_valid = 1'b0;
          seen = 1'b0;
          for (int i = 0; i < 40 && !seen; i++) begin
            if (i == bcyc) tx_busy = 1'b0;
            tick();
            if (tx_valid) seen = 1'b1;
          end
          tx_busy = 1'b0;
          check("rnd_tx_seen", seen, 1'b1);
          exp_rd.push_back(int'(a));
          exp_tx.push_back(int'(d));
        end
        2: begin
          do d = 8'($urandom_range(0, 255)); while (d == 8'hAA || d == 8'hBB);
          send_byte(d);
          exp_ferr = 1;
        end
        default: begin
          send_byte(($urandom_range(0, 1) == 1) ? 8'hAA : 8'hBB);
          idle(int'($urandom_range(0, 3)));
          send_byte(8'($urandom_range(16, 255)));
          exp_ferr = 1;
        end
      endcase
      idle(2);
      check("rnd_ferr", ferr_seen - fbase, exp_ferr);
      check("rnd_idle", busy, 1'b0);
      check("rnd_wr_cnt", wr_q.size(), exp_wr.size());
      check("rnd_rd_cnt", rd_q.size(), exp_rd.size());
      check("rnd_tx_cnt", tx_q.size(), exp_tx.size());
      for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) check("rnd_wr", wr_q[i], exp_wr[i]);
      for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++) check("rnd_rd", rd_q[i], exp_rd[i]);
      for (int i = 0; i < tx_q.size() && i < exp_tx.size(); i++) check("rnd_tx", tx_q[i], exp_tx[i]);
      wr_q.delete(); rd_q.delete(); tx_q.delete();
      exp_wr.delete(); exp_rd.delete(); exp_tx.delete();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
